// File: rtl/scr1_tcm_portb_arb.sv
// TCM port B arbiter: shares the data port between the core dmem bus and the
// accelerator master. It handles starvation, lock bursts and core byte-lane formatting.

package scr1_memif_pkg;
    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_ERROR = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;
endpackage

module scr1_tcm_portb_arb
    import scr1_memif_pkg::*;
#(
    parameter int unsigned SCR1_TCM_SIZE = 32'h00010000,
    parameter int unsigned ACC_MAX_WAIT  = 4,
    parameter int unsigned LOCK_MAX      = 8,
    localparam int unsigned AW           = $clog2(SCR1_TCM_SIZE) - 2
) (
    input  logic                 clk,
    input  logic                 rst,
    // core dmem
    input  logic                 dmem_req,
    input  type_scr1_mem_cmd_e   dmem_cmd,
    input  type_scr1_mem_width_e dmem_width,
    input  logic [31:0]          dmem_addr,
    input  logic [31:0]          dmem_wdata,
    output logic                 dmem_req_ack,
    output logic [31:0]          dmem_rdata,
    output type_scr1_mem_resp_e  dmem_resp,
    // accelerator
    input  logic                 acc_req,
    input  logic                 acc_we,
    input  logic                 acc_lock,
    input  logic [AW-1:0]        acc_addr,
    input  logic [31:0]          acc_wdata,
    input  logic [3:0]           acc_be,
    output logic                 acc_gnt,
    output logic                 acc_rvalid,
    output logic [31:0]          acc_rdata,
    // memory port B
    output logic                 mem_renb,
    output logic                 mem_wenb,
    output logic [3:0]           mem_webb,
    output logic [AW-1:0]        mem_addrb,
    output logic [31:0]          mem_datab,
    input  logic [31:0]          mem_qb
);

    localparam int unsigned SW = (ACC_MAX_WAIT < 1) ? 1 : $clog2(ACC_MAX_WAIT + 1);
    localparam int unsigned LW = (LOCK_MAX < 2) ? 1 : $clog2(LOCK_MAX + 1);

    typedef enum logic {StArb, StLock} state_e;
    typedef enum logic [1:0] {OwnNone, OwnCore, OwnAcc} owner_e;

    state_e              state;
    owner_e              rd_owner;
    logic [SW-1:0]       starve_cnt;
    logic [LW-1:0]       lock_cnt;
    logic                core_prio;
    logic [1:0]          shift_reg;
    type_scr1_mem_resp_e resp_reg;

    logic                core_win;
    logic                acc_win;
    logic                starved;
    logic                lock_last;
    logic [31:0]         core_data;
    logic [3:0]          core_be;
    logic [31-AW-2:0]    unused_addr_hi;

    assign unused_addr_hi = dmem_addr[31:AW+2];
    assign starved        = (starve_cnt == SW'(ACC_MAX_WAIT));
    // This lock grant brings the burst count to LOCK_MAX.
    assign lock_last      = (state == StLock) && acc_win && (lock_cnt == LW'(LOCK_MAX - 1));

    // Grant decision; no grants at all while reset is asserted.
    always_comb begin
        acc_win  = 1'b0;
        core_win = 1'b0;
        if (!rst) begin
            if (state == StLock) begin
                acc_win = acc_req;
            end else begin
                acc_win  = acc_req && (!dmem_req || starved) && !core_prio;
                core_win = dmem_req && !acc_win;
            end
        end
    end

    assign dmem_req_ack = core_win;
    assign acc_gnt      = acc_win;

    // Core write replication and byte enables from width and address offset.
    always_comb begin
        core_data = dmem_wdata;
        core_be   = 4'hF;
        unique case (dmem_width)
            SCR1_MEM_WIDTH_BYTE: begin
                core_data = {4{dmem_wdata[7:0]}};
                core_be   = 4'b0001 << dmem_addr[1:0];
            end
            SCR1_MEM_WIDTH_HWORD: begin
                core_data = {2{dmem_wdata[15:0]}};
                core_be   = 4'b0011 << {dmem_addr[1], 1'b0};
            end
            default: begin
                core_data = dmem_wdata;
                core_be   = 4'hF;
            end
        endcase
    end

    // Port B mux; address/data default to the core side when idle.
    always_comb begin
        mem_renb  = 1'b0;
        mem_wenb  = 1'b0;
        mem_webb  = core_be;
        mem_addrb = dmem_addr[AW+1:2];
        mem_datab = core_data;
        if (acc_win) begin
            mem_renb  = !acc_we;
            mem_wenb  = acc_we;
            mem_webb  = acc_be;
            mem_addrb = acc_addr;
            mem_datab = acc_wdata;
        end else if (core_win) begin
            mem_renb = (dmem_cmd == SCR1_MEM_CMD_RD);
            mem_wenb = (dmem_cmd == SCR1_MEM_CMD_WR);
        end
    end

    // Arbitration state, counters and response pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StArb;
            rd_owner   <= OwnNone;
            starve_cnt <= '0;
            lock_cnt   <= '0;
            core_prio  <= 1'b0;
            shift_reg  <= 2'b00;
            resp_reg   <= SCR1_MEM_RESP_NOTRDY;
        end else begin
            if (core_win && (dmem_cmd == SCR1_MEM_CMD_RD)) begin
                rd_owner  <= OwnCore;
                shift_reg <= dmem_addr[1:0];
            end else if (acc_win && !acc_we) begin
                rd_owner <= OwnAcc;
            end else begin
                rd_owner <= OwnNone;
            end

            resp_reg <= core_win ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_NOTRDY;

            if (!acc_req || acc_win) begin
                starve_cnt <= '0;
            end else if (!starved) begin
                starve_cnt <= starve_cnt + 1'b1;
            end

            if (lock_last) begin
                core_prio <= 1'b1;
            end else if (core_prio && (!dmem_req || core_win)) begin
                core_prio <= 1'b0;
            end

            case (state)
                StArb: begin
                    if (acc_win && acc_lock) begin
                        if (LOCK_MAX > 1) begin
                            state    <= StLock;
                            lock_cnt <= LW'(1);
                        end else begin
                            // A one-access burst is already at the limit.
                            core_prio <= 1'b1;
                        end
                    end
                end
                StLock: begin
                    if (!acc_req || lock_last || !acc_lock) begin
                        state    <= StArb;
                        lock_cnt <= '0;
                    end else begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= StArb;
                    lock_cnt <= '0;
                end
            endcase
        end
    end

    assign dmem_resp  = resp_reg;
    assign dmem_rdata = mem_qb >> {shift_reg, 3'b000};
    assign acc_rvalid = (rd_owner == OwnAcc);
    assign acc_rdata  = mem_qb;

endmodule

// File: tb/tb_scr1_tcm_portb_arb.sv
// Directed bench for the TCM port B arbiter with a small port B memory model.

module tb_scr1_tcm_portb_arb;
    import scr1_memif_pkg::*;

    localparam int unsigned AW = 14;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 dmem_req = 1'b0;
    type_scr1_mem_cmd_e   dmem_cmd = SCR1_MEM_CMD_RD;
    type_scr1_mem_width_e dmem_width = SCR1_MEM_WIDTH_WORD;
    logic [31:0]          dmem_addr = '0;
    logic [31:0]          dmem_wdata = '0;
    logic                 dmem_req_ack;
    logic [31:0]          dmem_rdata;
    type_scr1_mem_resp_e  dmem_resp;
    logic                 acc_req = 1'b0;
    logic                 acc_we = 1'b0;
    logic                 acc_lock = 1'b0;
    logic [AW-1:0]        acc_addr = '0;
    logic [31:0]          acc_wdata = '0;
    logic [3:0]           acc_be = 4'hF;
    logic                 acc_gnt;
    logic                 acc_rvalid;
    logic [31:0]          acc_rdata;
    logic                 mem_renb;
    logic                 mem_wenb;
    logic [3:0]           mem_webb;
    logic [AW-1:0]        mem_addrb;
    logic [31:0]          mem_datab;
    logic [31:0]          mem_qb;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    // Port B memory: word i holds 0x11110000+i after reset, 1-cycle read latency.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h11110000 + i;
            mem_qb <= '0;
        end else begin
            if (mem_wenb) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_webb[b]) mem[mem_addrb[7:0]][8*b +: 8] <= mem_datab[8*b +: 8];
                end
            end
            if (mem_renb) mem_qb <= mem[mem_addrb[7:0]];
        end
    end

    scr1_tcm_portb_arb dut (
        .clk          (clk),
        .rst          (rst),
        .dmem_req     (dmem_req),
        .dmem_cmd     (dmem_cmd),
        .dmem_width   (dmem_width),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_req_ack (dmem_req_ack),
        .dmem_rdata   (dmem_rdata),
        .dmem_resp    (dmem_resp),
        .acc_req      (acc_req),
        .acc_we       (acc_we),
        .acc_lock     (acc_lock),
        .acc_addr     (acc_addr),
        .acc_wdata    (acc_wdata),
        .acc_be       (acc_be),
        .acc_gnt      (acc_gnt),
        .acc_rvalid   (acc_rvalid),
        .acc_rdata    (acc_rdata),
        .mem_renb     (mem_renb),
        .mem_wenb     (mem_wenb),
        .mem_webb     (mem_webb),
        .mem_addrb    (mem_addrb),
        .mem_datab    (mem_datab),
        .mem_qb       (mem_qb)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic core_drive(input logic req, input type_scr1_mem_cmd_e cmd,
                              input type_scr1_mem_width_e w, input logic [31:0] a,
                              input logic [31:0] d);
        dmem_req   = req;
        dmem_cmd   = cmd;
        dmem_width = w;
        dmem_addr  = a;
        dmem_wdata = d;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        dmem_req = 1'b1;
        acc_req  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_tests++;
            if ({dmem_req_ack, acc_gnt, mem_renb, mem_wenb} !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_grants c%0d: got %b want 0000", c,
                         {dmem_req_ack, acc_gnt, mem_renb, mem_wenb});
            end
            n_tests++;
            if (dmem_resp !== SCR1_MEM_RESP_NOTRDY || acc_rvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_resp c%0d: got resp %0d rvalid %b want 0 0", c,
                         dmem_resp, acc_rvalid);
            end
        end
        step();
        dmem_req = 1'b0;
        acc_req  = 1'b0;
        rst      = 1'b0;
        step();
    endtask

    task automatic test_core_wr_rd();
        // SB 0xA5 -> 0x103
        core_drive(1'b1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, 32'h103, 32'h000000A5);
        @(negedge clk);
        n_tests++;
        if ({dmem_req_ack, mem_wenb, mem_renb} !== 3'b110 || mem_webb !== 4'b1000 ||
            mem_datab !== 32'hA5A5A5A5 || mem_addrb !== 14'h40) begin
            n_fail++;
            $display("FAIL sb_drive: got ack/we/re %b be %b data %h addr %h want 110 1000 a5a5a5a5 40",
                     {dmem_req_ack, mem_wenb, mem_renb}, mem_webb, mem_datab, mem_addrb);
        end
        step();
        // LW 0x100
        core_drive(1'b1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h100, 32'h0);
        @(negedge clk);
        n_tests++;
        if (dmem_resp !== SCR1_MEM_RESP_RDY_OK || {dmem_req_ack, mem_renb, mem_wenb} !== 3'b110) begin
            n_fail++;
            $display("FAIL lw_drive: got resp %0d ack/re/we %b want 1 110", dmem_resp,
                     {dmem_req_ack, mem_renb, mem_wenb});
        end
        step();
        // LB 0x103
        core_drive(1'b1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE, 32'h103, 32'h0);
        @(negedge clk);
        n_tests++;
        if (dmem_resp !== SCR1_MEM_RESP_RDY_OK || dmem_rdata !== 32'hA5110040) begin
            n_fail++;
            $display("FAIL lw_data: got resp %0d data %h want 1 a5110040", dmem_resp, dmem_rdata);
        end
        step();
        // SH 0xBEEF -> 0x102
        core_drive(1'b1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, 32'h102, 32'h1234BEEF);
        @(negedge clk);
        n_tests++;
        if (dmem_rdata !== 32'h000000A5 || dmem_resp !== SCR1_MEM_RESP_RDY_OK) begin
            n_fail++;
            $display("FAIL lb_data: got resp %0d data %h want 1 000000a5", dmem_resp, dmem_rdata);
        end
        n_tests++;
        if (mem_webb !== 4'b1100 || mem_datab !== 32'hBEEFBEEF || mem_wenb !== 1'b1) begin
            n_fail++;
            $display("FAIL sh_drive: got be %b data %h we %b want 1100 beefbeef 1", mem_webb,
                     mem_datab, mem_wenb);
        end
        step();
        // LH 0x102
        core_drive(1'b1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h102, 32'h0);
        step();
        core_drive(1'b0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0, 32'h0);
        @(negedge clk);
        n_tests++;
        if (dmem_rdata !== 32'h0000BEEF || dmem_resp !== SCR1_MEM_RESP_RDY_OK) begin
            n_fail++;
            $display("FAIL lh_data: got resp %0d data %h want 1 0000beef", dmem_resp, dmem_rdata);
        end
        step();
        @(negedge clk);
        n_tests++;
        if (dmem_resp !== SCR1_MEM_RESP_NOTRDY) begin
            n_fail++;
            $display("FAIL resp_idle: got %0d want 0", dmem_resp);
        end
        step();
    endtask

    task automatic test_contention();
        logic exp_ack;
        core_drive(1'b1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0, 32'h0);
        acc_req  = 1'b1;
        acc_we   = 1'b0;
        acc_lock = 1'b0;
        acc_addr = 14'h10;
        for (int c = 0; c < 10; c++) begin
            exp_ack = ((c % 5) != 4);
            @(negedge clk);
            n_tests++;
            if (dmem_req_ack !== exp_ack || acc_gnt !== !exp_ack) begin
                n_fail++;
                $display("FAIL contention c%0d: got ack %b gnt %b want %b %b", c, dmem_req_ack,
                         acc_gnt, exp_ack, !exp_ack);
            end
            step();
        end
        dmem_req = 1'b0;
        acc_req  = 1'b0;
        step();
        step();
    endtask

    task automatic test_lock_burst();
        int          k;
        logic        exp_gnt;
        logic        exp_rv;
        logic [31:0] exp_rd;
        k        = 0;
        exp_rd   = '0;
        acc_lock = 1'b1;
        acc_we   = 1'b0;
        core_drive(1'b0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0, 32'h0);
        for (int c = 0; c < 12; c++) begin
            dmem_req = (c >= 1 && c <= 8);
            acc_req  = (k < 10);
            acc_addr = 14'h20 + 14'(k);
            exp_gnt  = (c <= 7) || (c == 9) || (c == 10);
            exp_rv   = (c >= 1 && c <= 8) || (c == 10) || (c == 11);
            @(negedge clk);
            n_tests++;
            if (acc_gnt !== exp_gnt || dmem_req_ack !== (c == 8)) begin
                n_fail++;
                $display("FAIL lock_grant c%0d: got gnt %b ack %b want %b %b", c, acc_gnt,
                         dmem_req_ack, exp_gnt, (c == 8));
            end
            n_tests++;
            if (acc_rvalid !== exp_rv || (exp_rv && acc_rdata !== exp_rd)) begin
                n_fail++;
                $display("FAIL lock_rvalid c%0d: got %b %h want %b %h", c, acc_rvalid, acc_rdata,
                         exp_rv, exp_rd);
            end
            if (c == 9) begin
                n_tests++;
                if (dmem_resp !== SCR1_MEM_RESP_RDY_OK || dmem_rdata !== 32'h11110000) begin
                    n_fail++;
                    $display("FAIL lock_core_data: got %0d %h want 1 11110000", dmem_resp,
                             dmem_rdata);
                end
            end
            if (exp_gnt) begin
                exp_rd = 32'h11110020 + k;
                k++;
            end
            step();
        end
        acc_lock = 1'b0;
        acc_req  = 1'b0;
        dmem_req = 1'b0;
        step();
    endtask

    task automatic test_interleave();
        core_drive(1'b1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h104, 32'h0);
        acc_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if (dmem_req_ack !== 1'b1 || acc_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL ilv_core_ack: got %b %b want 1 0", dmem_req_ack, acc_gnt);
        end
        step();
        dmem_req = 1'b0;
        acc_req  = 1'b1;
        acc_we   = 1'b0;
        acc_addr = 14'h42;
        @(negedge clk);
        n_tests++;
        if (acc_gnt !== 1'b1 || dmem_resp !== SCR1_MEM_RESP_RDY_OK ||
            dmem_rdata !== 32'h11110041 || acc_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL ilv_n1: got gnt %b resp %0d data %h rv %b want 1 1 11110041 0",
                     acc_gnt, dmem_resp, dmem_rdata, acc_rvalid);
        end
        step();
        acc_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if (acc_rvalid !== 1'b1 || acc_rdata !== 32'h11110042 ||
            dmem_resp !== SCR1_MEM_RESP_NOTRDY) begin
            n_fail++;
            $display("FAIL ilv_n2: got rv %b data %h resp %0d want 1 11110042 0", acc_rvalid,
                     acc_rdata, dmem_resp);
        end
        step();
    endtask

    task automatic test_reset_mid_read();
        logic exp_ack;
        acc_req  = 1'b1;
        acc_we   = 1'b0;
        acc_addr = 14'h30;
        @(negedge clk);
        n_tests++;
        if (acc_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_gnt: got %b want 1", acc_gnt);
        end
        step();
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (acc_rvalid !== 1'b0 || acc_gnt !== 1'b0 || dmem_resp !== SCR1_MEM_RESP_NOTRDY) begin
            n_fail++;
            $display("FAIL mid_rst: got rv %b gnt %b resp %0d want 0 0 0", acc_rvalid, acc_gnt,
                     dmem_resp);
        end
        step();
        acc_req = 1'b0;
        rst     = 1'b0;
        @(negedge clk);
        n_tests++;
        if (acc_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_after: got rv %b want 0", acc_rvalid);
        end
        step();
        // Fresh counters: core wins four times before the accelerator.
        core_drive(1'b1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0, 32'h0);
        acc_req = 1'b1;
        for (int c = 0; c < 5; c++) begin
            exp_ack = (c != 4);
            @(negedge clk);
            n_tests++;
            if (dmem_req_ack !== exp_ack || acc_gnt !== !exp_ack) begin
                n_fail++;
                $display("FAIL post_rst_arb c%0d: got ack %b gnt %b want %b %b", c, dmem_req_ack,
                         acc_gnt, exp_ack, !exp_ack);
            end
            step();
        end
        dmem_req = 1'b0;
        acc_req  = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_core_wr_rd();
        test_contention();
        test_lock_burst();
        test_interleave();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/scr1_tcm_portb_arb.md
# scr1_tcm_portb_arb

Arbiter and sequencer for data port B of the TCM dual-port memory. It shares that single read/write port between the core data interface (dmem) and the on-chip accelerator. It replaces the static enable-driven mux. It also owns the byte-lane formatting for core accesses: write replication, byte enables and read alignment. Port A (instruction fetch) is not touched. The block sits between the core dmem bus, the accelerator memory master and `scr1_dp_memory` port B.

## Interface
Parameters:
- SCR1_TCM_SIZE, 32'h00010000, TCM size in bytes; word address width AW = $clog2(SCR1_TCM_SIZE)-2.
- ACC_MAX_WAIT, 4, consecutive lost cycles after which a pending accelerator request beats the core.
- LOCK_MAX, 8, maximum accelerator accesses granted back-to-back under lock.

Ports:
- clk  in  1  clock (only clock).
- rst  in  1  reset, asynchronous, active-high.
- dmem_req  in  1  core request, held until acked.
- dmem_cmd  in  type_scr1_mem_cmd_e  RD/WR.
- dmem_width  in  type_scr1_mem_width_e  BYTE/HWORD/WORD.
- dmem_addr  in  32  byte address.
- dmem_wdata  in  32  write data, LSB-aligned.
- dmem_req_ack  out  1  combinational grant to core.
- dmem_rdata  out  32  read data, shifted right by 8*addr[1:0].
- dmem_resp  out  type_scr1_mem_resp_e  RDY_OK for one cycle after each accepted core access.
- acc_req  in  1  accelerator request.
- acc_we  in  1  1 = write.
- acc_lock  in  1  request to keep the port for following accesses.
- acc_addr  in  AW  word address.
- acc_wdata  in  32  write data.
- acc_be  in  4  byte enables.
- acc_gnt  out  1  combinational grant.
- acc_rvalid  out  1  read data valid, one cycle after a read grant.
- acc_rdata  out  32  read data (raw word).
- mem_renb, mem_wenb  out  1  port B read/write strobes.
- mem_webb  out  4  port B byte enables.
- mem_addrb  out  AW  port B word address.
- mem_datab  out  32  port B write data.
- mem_qb  in  32  port B read data, valid the cycle after mem_renb.

## Operation
- States: ARB (default), LOCK. Reset state is ARB.
- Counters:
  - starve_cnt (0..ACC_MAX_WAIT): increments while acc_req=1 and not granted; saturates; clears on acc grant or acc_req=0.
  - lock_cnt (0..LOCK_MAX): counts accesses granted in LOCK.
- ARB decision each cycle:
  - acc_win = acc_req & (~dmem_req | starve_cnt==ACC_MAX_WAIT) & ~core_prio.
  - dmem_req_ack = dmem_req & ~acc_win.
  - acc_gnt = acc_win.
  - Exactly one grant or none per cycle.
- ARB→LOCK when acc granted with acc_lock=1; lock_cnt ← 1.
- LOCK behaviour:
  - acc_gnt = acc_req, and dmem_req_ack = 0.
  - Each grant increments lock_cnt.
  - Exit to ARB when acc_lock=0 at a grant, when acc_req=0, or when the grant that makes lock_cnt==LOCK_MAX occurs.
  - An exit at LOCK_MAX sets core_prio. core_prio holds until the next cycle in which dmem_req=0 or the core is acked, then clears.
- Core byte-lane formatting:
  - BYTE: datab = {4{wdata[7:0]}}, webb = 1<<addr[1:0].
  - HWORD: datab = {2{wdata[15:0]}}, webb = 2'b11<<{addr[1],0}.
  - WORD: datab = wdata, webb = 4'hF.
- Port B drive:
  - With no grant, mem_renb = mem_wenb = 0. Address and data are don't-care but are driven from the core inputs.
  - On a core grant, renb/wenb follow dmem_cmd.
  - On an acc grant, renb = ~acc_we, wenb = acc_we, webb = acc_be.
- Response tracking:
  - A 1-cycle register rd_owner {NONE, CORE, ACC} records who was granted a read.
  - shift_reg records dmem_addr[1:0] on a core read grant.
  - dmem_rdata = mem_qb >> (8*shift_reg).
  - acc_rdata = mem_qb, with acc_rvalid = (rd_owner==ACC).
- dmem_resp = RDY_OK exactly the cycle after any core grant (read or write), otherwise NOTRDY. Back-to-back acks give back-to-back RDY_OK.

## Timing
- Grant and port B strobes are combinational in the request cycle. Read data is returned in cycle +1, and dmem_resp/acc_rvalid are registered.
- Full throughput: one access per cycle, with no bubble on owner switch, since rd_owner pipelines ownership.
- Reset values:
  - Registered outputs: dmem_resp = NOTRDY, acc_rvalid = 0.
  - Registered state: rd_owner = NONE, state = ARB, starve_cnt = lock_cnt = 0, core_prio = 0.
  - Combinational outputs: dmem_req_ack, acc_gnt, mem_renb and mem_wenb are 0 while rst=1.
- Reset asserted mid-operation drops any pending read return: no rvalid or RDY_OK follows.
- Simultaneous requests with starve_cnt < ACC_MAX_WAIT: the core wins. At the limit the accelerator wins once, then starve_cnt clears.

## Test plan
- Reset: hold rst 3 cycles with both requests high -> no grants, strobes 0, dmem_resp NOTRDY, acc_rvalid 0.
- Core write then read:
  - Stimulus: SB 0xA5 to byte addr 0x103, then LW 0x100.
  - Write cycle: webb = 4'b1000, datab = 32'hA5A5A5A5.
  - Read cycle: dmem_rdata[31:24] = 0xA5 on the RDY_OK cycle.
  - Then LB 0x103 -> dmem_rdata[7:0] = 0xA5.
- Contention: both requesting continuously with ACC_MAX_WAIT=4, acc_lock=0 -> core acked 4 cycles, acc granted cycle 5, repeating 4:1.
- Lock burst: acc_lock=1 with 10 reads pending and the core requesting -> 8 consecutive acc grants, each followed by acc_rvalid, then a core ack, then acc resumes.
- Interleaved reads: core read at cycle n, acc read at n+1 -> cycle n+1 gives dmem_resp RDY_OK with core data; cycle n+2 gives acc_rvalid with acc data; no cross-delivery.
- Reset mid-read: assert rst in the cycle after an acc read grant -> acc_rvalid stays 0; after release, state is ARB and counters are 0.
